// File: rtl/m1_tt_sweeper.sv
// Truth-table sweeper: drives all input vectors into an external function,
// captures its response after LAT cycles and compares against a golden table.
module m1_tt_sweeper #(
   parameter  int N_IN = 6,
   parameter  int LAT  = 1,
   localparam int TT_W = 2**N_IN
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   input  logic            abort_i,
   input  logic [TT_W-1:0] exp_tt_i,
   output logic [N_IN-1:0] x_o,
   input  logic            y_i,
   output logic            busy_o,
   output logic            done_o,
   output logic            aborted_o,
   output logic [TT_W-1:0] tt_o,
   output logic [N_IN:0]   ones_o,
   output logic            mismatch_o,
   output logic [N_IN-1:0] first_bad_o
);

   localparam int D = (LAT == 0) ? 1 : LAT;

   typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

   state_t          state, nxt;
   logic [N_IN:0]   idx;
   logic [D-1:0]    dv;
   logic [N_IN-1:0] dk [D];
   logic            issue, last, pend;
   logic            accept, abort_act;
   logic            cap_v, cap;
   logic [N_IN-1:0] cap_k;

   assign issue = (state == SWEEP);
   assign last  = (idx == (N_IN+1)'(TT_W-1));

   // With LAT=0 the issued tag is captured on the same edge it is issued.
   generate
      if (LAT == 0) begin : g_lat0
         assign cap_v = issue;
         assign cap_k = idx[N_IN-1:0];
      end else begin : g_latn
         assign cap_v = dv[D-1];
         assign cap_k = dk[D-1];
      end
   endgenerate

   assign cap = cap_v && !abort_act;

   // Tags still in flight beyond the one emerging this cycle.
   always_comb begin
      pend = 1'b0;
      for (int i = 0; i < D-1; i++) pend = pend | dv[i];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   always_comb begin
      nxt       = state;
      accept    = 1'b0;
      abort_act = 1'b0;
      unique case (state)
         IDLE: begin
            if (start_i) begin
               accept = 1'b1;
               nxt    = SWEEP;
            end
         end
         SWEEP: begin
            if (abort_i) begin
               abort_act = 1'b1;
               nxt       = IDLE;
            end else if (last) begin
               nxt = (LAT == 0) ? DONE : DRAIN;
            end
         end
         DRAIN: begin
            if (abort_i) begin
               abort_act = 1'b1;
               nxt       = IDLE;
            end else if (!pend) begin
               nxt = DONE;
            end
         end
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx         <= '0;
         dv          <= '0;
         for (int i = 0; i < D; i++) dk[i] <= '0;
         tt_o        <= '0;
         ones_o      <= '0;
         mismatch_o  <= 1'b0;
         first_bad_o <= '0;
         aborted_o   <= 1'b0;
      end else begin
         aborted_o <= abort_act;
         if (abort_act) begin
            dv <= '0;
         end else begin
            dv[0] <= issue;
            for (int i = 1; i < D; i++) dv[i] <= dv[i-1];
         end
         dk[0] <= idx[N_IN-1:0];
         for (int i = 1; i < D; i++) dk[i] <= dk[i-1];
         if (accept) begin
            idx         <= '0;
            tt_o        <= '0;
            ones_o      <= '0;
            mismatch_o  <= 1'b0;
            first_bad_o <= '0;
         end else begin
            if (issue && !abort_act && !last) idx <= idx + 1'b1;
            if (cap) begin
               tt_o[cap_k] <= y_i;
               ones_o      <= ones_o + (N_IN+1)'(y_i);
               if ((y_i != exp_tt_i[cap_k]) && !mismatch_o) begin
                  mismatch_o  <= 1'b1;
                  first_bad_o <= cap_k;
               end
            end
         end
      end
   end

   assign x_o    = (state == IDLE) ? '0 : idx[N_IN-1:0];
   assign busy_o = (state == SWEEP) || (state == DRAIN);
   assign done_o = (state == DONE);

endmodule

// File: tb/tb_m1_tt_sweeper.sv
// Directed bench for m1_tt_sweeper: four instances with LAT=0..3 share
// stimulus; each sees a stand-in function delayed by its own latency.
module tb_m1_tt_sweeper;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [63:0] exp_tt = '0;
   logic [1:0]  fsel = '0;

   logic [5:0]  x     [4];
   logic        y     [4];
   logic        busy  [4];
   logic        done  [4];
   logic        abrt  [4];
   logic [63:0] tt    [4];
   logic [6:0]  ones  [4];
   logic        mm    [4];
   logic [5:0]  fb    [4];

   int ntests = 0;
   int nfail  = 0;
   int lat [4];
   int cnt;

   always #5 clk = ~clk;

   function automatic logic fn(input logic [1:0] s, input logic [5:0] v);
      case (s)
         2'd0:    return v[0];
         2'd1:    return v[5] & v[4];
         default: return 1'b1;
      endcase
   endfunction

   genvar g;
   generate
      for (g = 0; g < 4; g++) begin : gi
         logic [3:0] yp = '0;
         m1_tt_sweeper #(.N_IN(6), .LAT(g)) dut (
            .clk(clk), .rst(rst), .start_i(start), .abort_i(abort),
            .exp_tt_i(exp_tt), .x_o(x[g]), .y_i(y[g]),
            .busy_o(busy[g]), .done_o(done[g]), .aborted_o(abrt[g]),
            .tt_o(tt[g]), .ones_o(ones[g]), .mismatch_o(mm[g]),
            .first_bad_o(fb[g])
         );
         always @(posedge clk) yp <= {yp[2:0], fn(fsel, x[g])};
         if (g == 0) begin : gc
            assign y[g] = fn(fsel, x[g]);
         end else begin : gd
            assign y[g] = yp[g-1];
         end
      end
   endgenerate

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] expv);
      ntests++;
      assert (obs === expv) else begin
         nfail++;
         $error("FAIL %s: got %0h want %0h", tag, obs, expv);
      end
   endtask

   // Start all instances and record the cycle of each done pulse.
   task automatic run_all();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      for (int i = 0; i < 4; i++) lat[i] = 0;
      for (int n = 1; n <= 80; n++) begin
         for (int i = 0; i < 4; i++)
            if (done[i] && lat[i] == 0) lat[i] = n;
         @(negedge clk);
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("rst_ctl%0d", i),
             64'({busy[i], done[i], abrt[i], mm[i], fb[i], ones[i], x[i]}),
             64'd0);
         chk($sformatf("rst_tt%0d", i), tt[i], 64'd0);
      end
      rst = 1'b0;
      @(negedge clk);

      // f = x0 across every latency
      fsel   = 2'd0;
      exp_tt = 64'hAAAA_AAAA_AAAA_AAAA;
      run_all();
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t1_lat%0d", i), 64'(lat[i]), 64'(65 + i));
         chk($sformatf("t1_tt%0d", i), tt[i], 64'hAAAA_AAAA_AAAA_AAAA);
      end
      chk("t1_ones", 64'(ones[1]), 64'd32);
      chk("t1_mm", 64'(mm[1]), 64'd0);
      chk("t1_fb", 64'(fb[1]), 64'd0);
      chk("t1_idle", 64'({busy[1], done[1]}), 64'd0);

      // f = x5 & x4 against a golden table with bit 61 wrong
      fsel   = 2'd1;
      exp_tt = 64'hDFFF_0000_0000_0000;
      run_all();
      chk("t2_tt", tt[1], 64'hFFFF_0000_0000_0000);
      chk("t2_ones", 64'(ones[1]), 64'd16);
      chk("t2_mm", 64'(mm[1]), 64'd1);
      chk("t2_fb", 64'(fb[1]), 64'd61);
      chk("t2_fb_l3", 64'(fb[3]), 64'd61);

      // constant 1, LAT=0
      fsel   = 2'd2;
      exp_tt = '1;
      run_all();
      chk("t3_ones", 64'(ones[0]), 64'h40);
      chk("t3_lat", 64'(lat[0]), 64'd65);
      chk("t3_mm", 64'(mm[0]), 64'd0);

      // abort at sweep cycle 20, then a clean sweep
      fsel   = 2'd0;
      exp_tt = 64'hAAAA_AAAA_AAAA_AAAA;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      cnt = 0;
      for (int n = 1; n < 20; n++) begin
         if (done[1]) cnt++;
         @(negedge clk);
      end
      abort = 1'b1;
      @(negedge clk) abort = 1'b0;
      chk("t4_abrt", 64'(abrt[1]), 64'd1);
      chk("t4_busy", 64'(busy[1]), 64'd0);
      for (int n = 0; n < 5; n++) begin
         if (done[1]) cnt++;
         @(negedge clk);
      end
      chk("t4_abrt_pulse", 64'(abrt[1]), 64'd0);
      chk("t4_nodone", 64'(cnt), 64'd0);
      run_all();
      chk("t4_lat", 64'(lat[1]), 64'd66);
      chk("t4_tt", tt[1], 64'hAAAA_AAAA_AAAA_AAAA);
      chk("t4_ones", 64'(ones[1]), 64'd32);

      // abort in IDLE ignored; start+abort in IDLE: start wins
      abort = 1'b1;
      @(negedge clk) abort = 1'b0;
      chk("idle_abort", 64'({abrt[1], busy[1]}), 64'd0);
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk) begin start = 1'b0; abort = 1'b0; end
      chk("start_win", 64'({busy[1], abrt[1]}), 64'b10);
      abort = 1'b1;
      @(negedge clk) abort = 1'b0;
      chk("late_abort", 64'({busy[1], abrt[1]}), 64'b01);
      @(negedge clk);

      // start held through a sweep and its DONE cycle
      @(negedge clk) start = 1'b1;
      @(negedge clk);
      cnt = 0;
      for (int n = 1; n <= 75; n++) begin
         if (done[1]) cnt++;
         if (n == 67) begin
            chk("t5_restart0", 64'(busy[0]), 64'd1);
            chk("t5_idle1", 64'(busy[1]), 64'd0);
            start = 1'b0;
         end
         @(negedge clk);
      end
      chk("t5_one_done", 64'(cnt), 64'd1);
      chk("t5_busy", 64'(busy[1]), 64'd0);
      repeat (70) @(negedge clk);

      // reset mid-DRAIN on LAT=3
      fsel = 2'd0;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      for (int n = 1; n < 66; n++) @(negedge clk);
      chk("t6_in_drain", 64'(busy[3]), 64'd1);
      rst = 1'b1;
      #1;
      chk("t6_ctl", 64'({busy[3], done[3], abrt[3], mm[3], ones[3], x[3]}),
          64'd0);
      chk("t6_tt", tt[3], 64'd0);
      @(negedge clk) rst = 1'b0;
      cnt = 0;
      for (int n = 0; n < 8; n++) begin
         if (done[3] || abrt[3]) cnt++;
         @(negedge clk);
      end
      chk("t6_nopulse", 64'(cnt), 64'd0);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
